// File: rtl/i2c_pkg.sv
// Shared types and constants for the write-only I2C target.
// Also hosts the majority-vote helper used by the optional line filter.
package i2c_pkg;

    localparam int   I2C_ADDR_W = 7;
    localparam int   I2C_DATA_W = 8;
    localparam logic RW_WRITE   = 1'b0;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        DATA     = 3'd3,
        DATA_ACK = 3'd4,
        IGNORE   = 3'd5
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/i2c_slave_write_if.sv
// Bus bundle between the I2C target and its surroundings: SCL in, received-byte outputs.
// SDA stays a plain inout on the top because it is an open-drain pad.
interface i2c_slave_write_if;
    import i2c_pkg::*;

    logic                  i_scl;
    logic [I2C_DATA_W-1:0] o_data;
    logic                  o_valid;
    logic                  o_busy;

    modport master (output i_scl, input o_data, input o_valid, input o_busy);
    modport slave  (input i_scl, output o_data, output o_valid, output o_busy);

endinterface

// File: rtl/i2c_line_sync.sv
// Synchronizer, optional 3-sample majority filter (I2C_SLAVE_GLITCH_FILTER_EN) and edge detect
// for one asynchronous I2C line. Idle-high reset values avoid false edges after reset.
module i2c_line_sync
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic reset_p,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;
    logic level_s;

    // two-flop synchronizer for the raw pin
    always_ff @(posedge clk) begin
        if (reset_p) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= pin;
            sync_r <= meta_r;
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] hist_r;
    logic       filt_r;

    // majority of the last three synchronized samples; a single-cycle pulse never wins
    always_ff @(posedge clk) begin
        if (reset_p) begin
            hist_r <= 2'b11;
            filt_r <= 1'b1;
        end else begin
            hist_r <= {hist_r[0], sync_r};
            filt_r <= maj3(sync_r, hist_r[0], hist_r[1]);
        end
    end

    assign level_s = filt_r;
`else
    assign level_s = sync_r;
`endif

    // one-flop history for edge detection
    always_ff @(posedge clk) begin
        if (reset_p) begin
            prev_r <= 1'b1;
        end else begin
            prev_r <= level_s;
        end
    end

    assign level = level_s;
    assign rise  = level_s & ~prev_r;
    assign fall  = ~level_s & prev_r;

endmodule

// File: rtl/i2c_slave_write.sv
// Write-only I2C target: detects START/STOP, matches SLAVE_ADDR, ACKs address and data,
// strobes each received byte. Optional line filter: I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_write
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h27
)(
    input  logic                   clk,
    input  logic                   reset_p,
    i2c_slave_write_if.slave       bus,
    inout  wire                    io_sda
);

    logic scl_level_s, scl_rise_s, scl_fall_s;
    logic sda_level_s, sda_rise_s, sda_fall_s;
    logic start_s, stop_s;
    logic [I2C_DATA_W-1:0] byte_s;

    state_t                state_r;
    logic [2:0]            bit_cnt_r;
    logic [I2C_DATA_W-1:0] shift_r;
    logic                  sda_drive_r;
    logic [I2C_DATA_W-1:0] data_r;
    logic                  valid_r;
    logic                  busy_r;

    i2c_line_sync u_scl_sync (
        .clk     (clk),
        .reset_p (reset_p),
        .pin     (bus.i_scl),
        .level   (scl_level_s),
        .rise    (scl_rise_s),
        .fall    (scl_fall_s)
    );

    i2c_line_sync u_sda_sync (
        .clk     (clk),
        .reset_p (reset_p),
        .pin     (io_sda),
        .level   (sda_level_s),
        .rise    (sda_rise_s),
        .fall    (sda_fall_s)
    );

    assign start_s = sda_fall_s & scl_level_s;
    assign stop_s  = sda_rise_s & scl_level_s;
    assign byte_s  = {shift_r[I2C_DATA_W-2:0], sda_level_s};

    // protocol FSM; START/STOP outrank any SCL edge seen in the same cycle
    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_r     <= IDLE;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'h00;
            sda_drive_r <= 1'b0;
            data_r      <= 8'h00;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (start_s) begin
                state_r     <= ADDR;
                bit_cnt_r   <= 3'd0;
                shift_r     <= 8'h00;
                sda_drive_r <= 1'b0;
            end else if (stop_s) begin
                state_r     <= IDLE;
                bit_cnt_r   <= 3'd0;
                shift_r     <= 8'h00;
                sda_drive_r <= 1'b0;
                busy_r      <= 1'b0;
            end else begin
                case (state_r)
                    ADDR: begin
                        if (scl_rise_s) begin
                            shift_r   <= byte_s;
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                if ((byte_s[I2C_DATA_W-1:1] == SLAVE_ADDR) && (byte_s[0] == RW_WRITE)) begin
                                    state_r <= ADDR_ACK;
                                end else begin
                                    state_r <= IGNORE;
                                    busy_r  <= 1'b0;
                                end
                            end
                        end
                    end
                    // first falling edge opens the ACK window, the next one closes it
                    ADDR_ACK, DATA_ACK: begin
                        if (scl_fall_s) begin
                            if (!sda_drive_r) begin
                                sda_drive_r <= 1'b1;
                                busy_r      <= 1'b1;
                            end else begin
                                sda_drive_r <= 1'b0;
                                state_r     <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (scl_rise_s) begin
                            shift_r   <= byte_s;
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                data_r  <= byte_s;
                                valid_r <= 1'b1;
                                state_r <= DATA_ACK;
                            end
                        end
                    end
                    IDLE, IGNORE: begin
                        sda_drive_r <= 1'b0;
                    end
                    default: begin
                        state_r     <= IDLE;
                        sda_drive_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign io_sda      = sda_drive_r ? 1'b0 : 1'bz;
    assign bus.o_data  = data_r;
    assign bus.o_valid = valid_r;
    assign bus.o_busy  = busy_r;

endmodule

// File: tb/tb_i2c_slave_write.sv
// Bench for i2c_slave_write: bit-banged I2C master, transaction-level reference model,
// directed scenarios plus randomized write/read traffic.
module tb_i2c_slave_write;

    logic clk = 1'b0;
    logic reset_p = 1'b1;
    logic m_sda_low = 1'b0;
    wire  sda_bus;

    always #5 clk = ~clk;

    i2c_slave_write_if bus_if ();

    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_slave_write #(.SLAVE_ADDR(7'h27)) dut (
        .clk     (clk),
        .reset_p (reset_p),
        .bus     (bus_if.slave),
        .io_sda  (sda_bus)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [7:0] obs_q[$];
    int         dut_low_cnt = 0;
    logic       busy_seen = 1'b0;

    logic [7:0] tx_q[$];
    logic       ack_q[$];
    logic       exp_ack_q[$];
    logic [7:0] exp_data_q[$];

    // passive monitor: collect strobed bytes, DUT pull-downs and busy activity
    always @(negedge clk) begin
        if (!reset_p) begin
            if (bus_if.o_valid) obs_q.push_back(bus_if.o_data);
            if (sda_bus === 1'b0 && !m_sda_low) dut_low_cnt <= dut_low_cnt + 1;
            if (bus_if.o_busy) busy_seen <= 1'b1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic clear_obs();
        obs_q.delete();
        ack_q.delete();
        dut_low_cnt = 0;
        busy_seen   = 1'b0;
    endtask

    task automatic i2c_start();
        if (bus_if.i_scl == 1'b0) begin
            wclk(4); m_sda_low = 1'b0;
            wclk(6); bus_if.i_scl = 1'b1;
        end
        wclk(8); m_sda_low = 1'b1;
        wclk(8); bus_if.i_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wclk(4);  m_sda_low = 1'b1;
        wclk(6);  bus_if.i_scl = 1'b1;
        wclk(8);  m_sda_low = 1'b0;
        wclk(10);
    endtask

    task automatic send_bit(input logic b);
        wclk(4);  m_sda_low = ~b;
        wclk(6);  bus_if.i_scl = 1'b1;
        wclk(10); bus_if.i_scl = 1'b0;
    endtask

    task automatic ack_clock(output logic ack);
        wclk(4); m_sda_low = 1'b0;
        wclk(6); bus_if.i_scl = 1'b1;
        wclk(5); ack = (sda_bus === 1'b0);
        wclk(5); bus_if.i_scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        ack_clock(ack);
    endtask

    task automatic do_xfer();
        logic a;
        i2c_start();
        foreach (tx_q[k]) begin
            send_byte(tx_q[k], a);
            ack_q.push_back(a);
        end
        i2c_stop();
    endtask

    // reference: the first byte addresses; only 0x27 with a write bit is acknowledged,
    // and then every complete following byte is acknowledged and delivered
    task automatic model_xfer();
        logic addressed;
        exp_ack_q.delete();
        exp_data_q.delete();
        addressed = (tx_q[0] >> 1) == 8'h27 && tx_q[0][0] == 1'b0;
        foreach (tx_q[k]) begin
            exp_ack_q.push_back(addressed);
            if (k > 0 && addressed) exp_data_q.push_back(tx_q[k]);
        end
    endtask

    task automatic test_reset();
        reset_p = 1'b1;
        wclk(4);
        @(negedge clk);
        vec_cnt++; if (bus_if.o_data !== 8'h00) begin err_cnt++; $display("FAIL reset_data: got %h expected 00", bus_if.o_data); end
        vec_cnt++; if (bus_if.o_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b expected 0", bus_if.o_valid); end
        vec_cnt++; if (bus_if.o_busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b expected 0", bus_if.o_busy); end
        vec_cnt++; if (sda_bus !== 1'b1) begin err_cnt++; $display("FAIL reset_sda: got %b expected 1 (released)", sda_bus); end
        reset_p = 1'b0;
        wclk(4);
    endtask

    task automatic test_write_single();
        clear_obs();
        tx_q = '{8'h4E, 8'h34};
        model_xfer();
        do_xfer();
        foreach (exp_ack_q[k]) begin
            vec_cnt++; if (ack_q[k] !== exp_ack_q[k]) begin err_cnt++; $display("FAIL single_ack[%0d]: got %b expected %b", k, ack_q[k], exp_ack_q[k]); end
        end
        vec_cnt++; if (obs_q.size() != 1 || obs_q[0] !== 8'h34) begin err_cnt++; $display("FAIL single_data: got %0d bytes first %h expected 1 byte 34", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 8'h00); end
        vec_cnt++; if (busy_seen !== 1'b1) begin err_cnt++; $display("FAIL single_busy_set: got %b expected 1", busy_seen); end
        vec_cnt++; if (bus_if.o_busy !== 1'b0) begin err_cnt++; $display("FAIL single_busy_clr: got %b expected 0", bus_if.o_busy); end
    endtask

    task automatic test_wrong_addr();
        clear_obs();
        tx_q = '{8'h4C, 8'h91};
        model_xfer();
        do_xfer();
        foreach (exp_ack_q[k]) begin
            vec_cnt++; if (ack_q[k] !== exp_ack_q[k]) begin err_cnt++; $display("FAIL wrong_ack[%0d]: got %b expected %b", k, ack_q[k], exp_ack_q[k]); end
        end
        vec_cnt++; if (dut_low_cnt != 0) begin err_cnt++; $display("FAIL wrong_sda_low: got %0d cycles expected 0", dut_low_cnt); end
        vec_cnt++; if (obs_q.size() != 0) begin err_cnt++; $display("FAIL wrong_valid: got %0d strobes expected 0", obs_q.size()); end
        vec_cnt++; if (busy_seen !== 1'b0) begin err_cnt++; $display("FAIL wrong_busy: got %b expected 0", busy_seen); end
    endtask

    task automatic test_two_bytes();
        clear_obs();
        tx_q = '{8'h4E, 8'h91, 8'h08};
        model_xfer();
        do_xfer();
        foreach (exp_ack_q[k]) begin
            vec_cnt++; if (ack_q[k] !== exp_ack_q[k]) begin err_cnt++; $display("FAIL two_ack[%0d]: got %b expected %b", k, ack_q[k], exp_ack_q[k]); end
        end
        vec_cnt++; if (obs_q.size() != exp_data_q.size()) begin err_cnt++; $display("FAIL two_count: got %0d expected %0d", obs_q.size(), exp_data_q.size()); end
        foreach (exp_data_q[k]) begin
            vec_cnt++; if (k >= obs_q.size() || obs_q[k] !== exp_data_q[k]) begin err_cnt++; $display("FAIL two_data[%0d]: got %h expected %h", k, k < obs_q.size() ? obs_q[k] : 8'h00, exp_data_q[k]); end
        end
    endtask

    task automatic test_read_nack();
        clear_obs();
        tx_q = '{8'h4F, 8'hAA};
        model_xfer();
        do_xfer();
        foreach (exp_ack_q[k]) begin
            vec_cnt++; if (ack_q[k] !== exp_ack_q[k]) begin err_cnt++; $display("FAIL read_ack[%0d]: got %b expected %b", k, ack_q[k], exp_ack_q[k]); end
        end
        vec_cnt++; if (obs_q.size() != 0) begin err_cnt++; $display("FAIL read_valid: got %0d strobes expected 0", obs_q.size()); end
        vec_cnt++; if (dut_low_cnt != 0) begin err_cnt++; $display("FAIL read_sda_low: got %0d cycles expected 0", dut_low_cnt); end
    endtask

    task automatic test_repeated_start();
        logic a1, a2, a3;
        logic [7:0] part;
        clear_obs();
        part = 8'hB0;
        i2c_start();
        send_byte(8'h4E, a1);
        for (int i = 7; i >= 4; i--) send_bit(part[i]);
        i2c_start();
        send_byte(8'h4E, a2);
        send_byte(8'h55, a3);
        i2c_stop();
        vec_cnt++; if ({a1, a2, a3} !== 3'b111) begin err_cnt++; $display("FAIL rs_acks: got %b expected 111", {a1, a2, a3}); end
        vec_cnt++; if (obs_q.size() != 1 || obs_q[0] !== 8'h55) begin err_cnt++; $display("FAIL rs_data: got %0d bytes first %h expected 1 byte 55", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 8'h00); end
    endtask

    task automatic test_random();
        logic [6:0] addr;
        logic       rw;
        int         n;
        for (int t = 0; t < 20; t++) begin
            clear_obs();
            addr = ($urandom_range(0, 1) == 0) ? 7'h27 : 7'($urandom_range(0, 127));
            if (t % 5 == 1 && addr == 7'h27) addr = 7'h26;
            rw = ($urandom_range(0, 3) == 0);
            n  = $urandom_range(1, 3);
            tx_q.delete();
            tx_q.push_back({addr, rw});
            for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
            model_xfer();
            do_xfer();
            foreach (exp_ack_q[k]) begin
                vec_cnt++; if (ack_q[k] !== exp_ack_q[k]) begin err_cnt++; $display("FAIL rnd%0d_ack[%0d]: got %b expected %b", t, k, ack_q[k], exp_ack_q[k]); end
            end
            vec_cnt++; if (obs_q.size() != exp_data_q.size()) begin err_cnt++; $display("FAIL rnd%0d_count: got %0d expected %0d", t, obs_q.size(), exp_data_q.size()); end
            foreach (exp_data_q[k]) begin
                vec_cnt++; if (k >= obs_q.size() || obs_q[k] !== exp_data_q[k]) begin err_cnt++; $display("FAIL rnd%0d_data[%0d]: got %h expected %h", t, k, k < obs_q.size() ? obs_q[k] : 8'h00, exp_data_q[k]); end
            end
        end
    endtask

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    task automatic test_glitch();
        logic a1, a2;
        logic [7:0] d;
        clear_obs();
        d = 8'h5A;
        i2c_start();
        send_byte(8'h4E, a1);
        for (int i = 7; i >= 0; i--) begin
            if (i == 3) begin
                wclk(2); bus_if.i_scl = 1'b1;
                wclk(1); bus_if.i_scl = 1'b0;
            end
            send_bit(d[i]);
        end
        ack_clock(a2);
        i2c_stop();
        vec_cnt++; if ({a1, a2} !== 2'b11) begin err_cnt++; $display("FAIL glitch_acks: got %b expected 11", {a1, a2}); end
        vec_cnt++; if (obs_q.size() != 1 || obs_q[0] !== 8'h5A) begin err_cnt++; $display("FAIL glitch_data: got %0d bytes first %h expected 1 byte 5a", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 8'h00); end
    endtask
`endif

    task automatic test_reset_mid_ack();
        logic a;
        int   waited;
        logic [7:0] d;
        clear_obs();
        d = 8'hC3;
        i2c_start();
        send_byte(8'h4E, a);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        wclk(4); m_sda_low = 1'b0;
        waited = 0;
        while (sda_bus !== 1'b0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        vec_cnt++; if (sda_bus !== 1'b0) begin err_cnt++; $display("FAIL rst_ack_drive: got %b expected 0 within 20 cycles", sda_bus); end
        @(negedge clk); reset_p = 1'b1;
        @(posedge clk); #1;
        vec_cnt++; if (sda_bus !== 1'b1) begin err_cnt++; $display("FAIL rst_ack_sda: got %b expected 1 (released)", sda_bus); end
        vec_cnt++; if (bus_if.o_data !== 8'h00) begin err_cnt++; $display("FAIL rst_ack_data: got %h expected 00", bus_if.o_data); end
        vec_cnt++; if (bus_if.o_valid !== 1'b0 || bus_if.o_busy !== 1'b0) begin err_cnt++; $display("FAIL rst_ack_flags: got valid=%b busy=%b expected 0 0", bus_if.o_valid, bus_if.o_busy); end
        i2c_stop();
        @(negedge clk); reset_p = 1'b0;
        wclk(4);
    endtask

    initial begin
        bus_if.i_scl = 1'b1;
        test_reset();
        test_write_single();
        test_wrong_addr();
        test_two_bytes();
        test_read_nack();
        test_repeated_start();
        test_random();
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        test_glitch();
`endif
        test_reset_mid_ack();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
